// File: rtl/mem_stage_if.sv
// EX->MEM->WB pipeline handshake and data-SRAM response bundle for the MEM stage.
// slave = MEM stage view, master = surrounding pipeline / testbench view.
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [4:0]  es_dest;
    logic [31:0] es_result;
    logic [2:0]  es_load_op;
    logic [31:0] es_rt_value;
    logic        es_req_sent;
    logic        es_excp_valid;
    logic [4:0]  es_excp_execode;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [4:0]  ms_dest;
    logic        ms_excp_valid;
    logic [4:0]  ms_excp_execode;
    logic [31:0] ms_final_result;
    logic        ms_fw_block;

    modport slave (
        input  es_to_ms_valid, es_pc, es_dest, es_result, es_load_op, es_rt_value,
               es_req_sent, es_excp_valid, es_excp_execode,
               data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_excp_valid,
               ms_excp_execode, ms_final_result, ms_fw_block
    );

    modport master (
        output es_to_ms_valid, es_pc, es_dest, es_result, es_load_op, es_rt_value,
               es_req_sent, es_excp_valid, es_excp_execode,
               data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_excp_valid,
               ms_excp_execode, ms_final_result, ms_fw_block
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, formats load data, hands off to WB.
// Define MS_UNALIGNED_LOAD_EN to add lwl/lwr merging; otherwise those ops format as lw.
//
// state     | meaning
// S_IDLE    | empty, ready to accept
// S_WAIT    | valid instruction, one data_ok still owed
// S_HOLD    | result ready, offered to WB until accepted
// S_DISCARD | contents killed by flush, owed data_ok must be swallowed
module mem_stage (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave ms_bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  dest_q, dest_d;
    logic        excp_q, excp_d;
    logic [4:0]  execode_q, execode_d;
    logic [2:0]  load_op_q, load_op_d;
`ifdef MS_UNALIGNED_LOAD_EN
    logic [31:0] rt_q, rt_d;
`endif

    logic        allowin;
    logic        accept;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign allowin = (state_q == S_IDLE) || (state_q == S_HOLD && ms_bus.ws_allowin);
    assign accept  = ms_bus.es_to_ms_valid && allowin && !ms_bus.flush;

    always_comb begin
        byte_sel  = ms_bus.data_sram_rdata[7:0];
        half_sel  = result_q[1] ? ms_bus.data_sram_rdata[31:16] : ms_bus.data_sram_rdata[15:0];
        load_data = ms_bus.data_sram_rdata;
        case (result_q[1:0])
            2'd1:    byte_sel = ms_bus.data_sram_rdata[15:8];
            2'd2:    byte_sel = ms_bus.data_sram_rdata[23:16];
            2'd3:    byte_sel = ms_bus.data_sram_rdata[31:24];
            default: byte_sel = ms_bus.data_sram_rdata[7:0];
        endcase
        case (load_op_q)
            3'b000: load_data = result_q;  // store: response is only an ack
            3'b010: load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b011: load_data = {24'd0, byte_sel};
            3'b100: load_data = {{16{half_sel[15]}}, half_sel};
            3'b101: load_data = {16'd0, half_sel};
`ifdef MS_UNALIGNED_LOAD_EN
            3'b110: begin
                case (result_q[1:0])
                    2'd0:    load_data = {ms_bus.data_sram_rdata[7:0],  rt_q[23:0]};
                    2'd1:    load_data = {ms_bus.data_sram_rdata[15:0], rt_q[15:0]};
                    2'd2:    load_data = {ms_bus.data_sram_rdata[23:0], rt_q[7:0]};
                    default: load_data = ms_bus.data_sram_rdata;
                endcase
            end
            3'b111: begin
                case (result_q[1:0])
                    2'd0:    load_data = ms_bus.data_sram_rdata;
                    2'd1:    load_data = {rt_q[31:24], ms_bus.data_sram_rdata[31:8]};
                    2'd2:    load_data = {rt_q[31:16], ms_bus.data_sram_rdata[31:16]};
                    default: load_data = {rt_q[31:8],  ms_bus.data_sram_rdata[31:24]};
                endcase
            end
`endif
            default: load_data = ms_bus.data_sram_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        result_d  = result_q;
        dest_d    = dest_q;
        excp_d    = excp_q;
        execode_d = execode_q;
        load_op_d = load_op_q;
`ifdef MS_UNALIGNED_LOAD_EN
        rt_d      = rt_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (ms_bus.flush)
                    state_d = ms_bus.data_sram_data_ok ? S_IDLE : S_DISCARD;
                else if (ms_bus.data_sram_data_ok) begin
                    state_d  = S_HOLD;
                    result_d = load_data;
                end
            end
            S_HOLD: begin
                if (ms_bus.flush || ms_bus.ws_allowin)
                    state_d = S_IDLE;
            end
            S_DISCARD: begin
                if (ms_bus.data_sram_data_ok)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // An accepted request owes exactly one data_ok, so it must wait even if faulting.
        if (accept) begin
            state_d   = ms_bus.es_req_sent ? S_WAIT : S_HOLD;
            pc_d      = ms_bus.es_pc;
            result_d  = ms_bus.es_result;
            dest_d    = ms_bus.es_excp_valid ? 5'd0 : ms_bus.es_dest;
            excp_d    = ms_bus.es_excp_valid;
            execode_d = ms_bus.es_excp_execode;
            load_op_d = ms_bus.es_load_op;
`ifdef MS_UNALIGNED_LOAD_EN
            rt_d      = ms_bus.es_rt_value;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= 32'd0;
            result_q  <= 32'd0;
            dest_q    <= 5'd0;
            excp_q    <= 1'b0;
            execode_q <= 5'd0;
            load_op_q <= 3'd0;
`ifdef MS_UNALIGNED_LOAD_EN
            rt_q      <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            result_q  <= result_d;
            dest_q    <= dest_d;
            excp_q    <= excp_d;
            execode_q <= execode_d;
            load_op_q <= load_op_d;
`ifdef MS_UNALIGNED_LOAD_EN
            rt_q      <= rt_d;
`endif
        end
    end

    assign ms_bus.ms_allowin      = allowin;
    assign ms_bus.ms_to_ws_valid  = (state_q == S_HOLD) && !ms_bus.flush;
    assign ms_bus.ms_fw_block     = (state_q == S_WAIT) && (dest_q != 5'd0);
    assign ms_bus.ms_pc           = pc_q;
    assign ms_bus.ms_dest         = dest_q;
    assign ms_bus.ms_excp_valid   = excp_q;
    assign ms_bus.ms_excp_execode = execode_q;
    assign ms_bus.ms_final_result = result_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: load formatting, WB back-pressure, flush/discard, exceptions, reset priority.
module tb_mem_stage;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_stage_if bus();
    mem_stage dut (.clk(clk), .reset(reset), .ms_bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res,
                         input logic [2:0] op, input logic [31:0] rt, input logic req,
                         input logic ex, input logic [4:0] code);
        bus.es_pc           = pc;
        bus.es_dest         = dest;
        bus.es_result       = res;
        bus.es_load_op      = op;
        bus.es_rt_value     = rt;
        bus.es_req_sent     = req;
        bus.es_excp_valid   = ex;
        bus.es_excp_execode = code;
        bus.es_to_ms_valid  = 1'b1;
        cyc();
        bus.es_to_ms_valid  = 1'b0;
        bus.es_excp_valid   = 1'b0;
        bus.es_req_sent     = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] rt, input logic [31:0] rdata, input logic [31:0] exp);
        bus.ws_allowin = 1'b1;
        issue(32'h700, 5'd11, addr, op, rt, 1'b1, 1'b0, 5'd0);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = rdata;
        cyc();
        bus.data_sram_data_ok = 1'b0;
        #1;
        check(tag, bus.ms_final_result, exp);
        cyc();
    endtask

    initial begin
        bus.es_to_ms_valid = 1'b0;
        bus.es_pc = '0; bus.es_dest = '0; bus.es_result = '0; bus.es_load_op = '0;
        bus.es_rt_value = '0; bus.es_req_sent = 1'b0; bus.es_excp_valid = 1'b0;
        bus.es_excp_execode = '0; bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = '0;
        bus.flush = 1'b0; bus.ws_allowin = 1'b1;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        check("rst_valid",   32'(bus.ms_to_ws_valid), 32'd0);
        check("rst_allowin", 32'(bus.ms_allowin), 32'd1);
        check("rst_fw",      32'(bus.ms_fw_block), 32'd0);
        check("rst_result",  bus.ms_final_result, 32'd0);
        check("rst_pc",      bus.ms_pc, 32'd0);
        check("rst_excp",    32'(bus.ms_excp_valid), 32'd0);

        // lb from byte 3, response two cycles after accept
        issue(32'h100, 5'd5, 32'h1003, 3'b010, 32'd0, 1'b1, 1'b0, 5'd0);
        #1;
        check("lb_fw1",      32'(bus.ms_fw_block), 32'd1);
        check("lb_allowin",  32'(bus.ms_allowin), 32'd0);
        check("lb_valid_w",  32'(bus.ms_to_ws_valid), 32'd0);
        cyc();
        check("lb_fw2",      32'(bus.ms_fw_block), 32'd1);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h80FF1234;
        cyc();
        bus.data_sram_data_ok = 1'b0;
        #1;
        check("lb_valid",    32'(bus.ms_to_ws_valid), 32'd1);
        check("lb_result",   bus.ms_final_result, 32'hFFFFFF80);
        check("lb_dest",     32'(bus.ms_dest), 32'd5);
        check("lb_pc",       bus.ms_pc, 32'h100);
        check("lb_fw_off",   32'(bus.ms_fw_block), 32'd0);
        cyc();
        check("lb_idle_v",   32'(bus.ms_to_ws_valid), 32'd0);
        check("lb_idle_a",   32'(bus.ms_allowin), 32'd1);

        // lhu upper half held under WB back-pressure, next instruction waiting in EX
        issue(32'h200, 5'd7, 32'h2002, 3'b101, 32'd0, 1'b1, 1'b0, 5'd0);
        bus.ws_allowin        = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h9ABC5678;
        cyc();
        bus.data_sram_data_ok = 1'b0;
        bus.es_pc = 32'h300; bus.es_dest = 5'd8; bus.es_result = 32'h55;
        bus.es_load_op = 3'b000; bus.es_req_sent = 1'b0;
        bus.es_to_ms_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lhu_valid",   32'(bus.ms_to_ws_valid), 32'd1);
            check("lhu_result",  bus.ms_final_result, 32'h00009ABC);
            check("lhu_allowin", 32'(bus.ms_allowin), 32'd0);
            check("lhu_pc",      bus.ms_pc, 32'h200);
            cyc();
        end
        bus.ws_allowin = 1'b1;
        #1;
        check("bb_allowin", 32'(bus.ms_allowin), 32'd1);
        cyc();
        bus.es_to_ms_valid = 1'b0;
        #1;
        check("bb_pc",     bus.ms_pc, 32'h300);
        check("bb_result", bus.ms_final_result, 32'h55);
        check("bb_dest",   32'(bus.ms_dest), 32'd8);
        check("bb_valid",  32'(bus.ms_to_ws_valid), 32'd1);
        cyc();
        check("bb_idle",   32'(bus.ms_allowin), 32'd1);

        // flush while waiting, data arrives one cycle later and must be dropped
        issue(32'h400, 5'd9, 32'h4000, 3'b001, 32'd0, 1'b1, 1'b0, 5'd0);
        bus.flush = 1'b1;
        #1;
        check("fl_valid", 32'(bus.ms_to_ws_valid), 32'd0);
        check("fl_fw",    32'(bus.ms_fw_block), 32'd1);
        cyc();
        bus.flush = 1'b0;
        #1;
        check("dis_fw",      32'(bus.ms_fw_block), 32'd0);
        check("dis_valid",   32'(bus.ms_to_ws_valid), 32'd0);
        check("dis_allowin", 32'(bus.ms_allowin), 32'd0);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hDEADBEEF;
        cyc();
        bus.data_sram_data_ok = 1'b0;
        #1;
        check("dis_done_a",  32'(bus.ms_allowin), 32'd1);
        check("dis_done_v",  32'(bus.ms_to_ws_valid), 32'd0);
        check("dis_result",  bus.ms_final_result, 32'h4000);

        // upstream exception passes straight through, then gets flushed out of HOLD
        issue(32'h500, 5'd3, 32'h77, 3'b001, 32'd0, 1'b0, 1'b1, 5'h04);
        #1;
        check("ex_valid",  32'(bus.ms_to_ws_valid), 32'd1);
        check("ex_excp",   32'(bus.ms_excp_valid), 32'd1);
        check("ex_code",   32'(bus.ms_excp_execode), 32'h04);
        check("ex_dest",   32'(bus.ms_dest), 32'd0);
        check("ex_fw",     32'(bus.ms_fw_block), 32'd0);
        check("ex_result", bus.ms_final_result, 32'h77);
        bus.ws_allowin = 1'b0;
        bus.flush      = 1'b1;
        #1;
        check("exfl_valid", 32'(bus.ms_to_ws_valid), 32'd0);
        cyc();
        bus.flush      = 1'b0;
        bus.ws_allowin = 1'b1;
        #1;
        check("exfl_allowin", 32'(bus.ms_allowin), 32'd1);
        check("exfl_idle_v",  32'(bus.ms_to_ws_valid), 32'd0);

        // load formatting table
        load_case("lbu_b1",  3'b011, 32'h0701, 32'd0, 32'h80FF9234, 32'h00000092);
        load_case("lb_b1",   3'b010, 32'h0701, 32'd0, 32'h80FF9234, 32'hFFFFFF92);
        load_case("lh_h0",   3'b100, 32'h0700, 32'd0, 32'h12348001, 32'hFFFF8001);
        load_case("lhu_h1",  3'b101, 32'h0702, 32'd0, 32'h80015678, 32'h00008001);
        load_case("lw",      3'b001, 32'h0704, 32'd0, 32'hCAFEF00D, 32'hCAFEF00D);
        load_case("store",   3'b000, 32'h0888, 32'd0, 32'h12345678, 32'h00000888);
`ifdef MS_UNALIGNED_LOAD_EN
        load_case("lwl_a1",  3'b110, 32'h0601, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344);
        load_case("lwr_a2",  3'b111, 32'h0602, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB);
        load_case("lwr_a3",  3'b111, 32'h0603, 32'h11223344, 32'hAABBCCDD, 32'h112233AA);
`else
        load_case("lwl_a1",  3'b110, 32'h0601, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD);
        load_case("lwr_a2",  3'b111, 32'h0602, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD);
`endif

        // flush and data_ok in the same WAIT cycle leaves nothing owed
        issue(32'h800, 5'd12, 32'h800, 3'b001, 32'd0, 1'b1, 1'b0, 5'd0);
        bus.flush = 1'b1;
        bus.data_sram_data_ok = 1'b1;
        cyc();
        bus.flush = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        #1;
        check("fd_allowin", 32'(bus.ms_allowin), 32'd1);
        check("fd_valid",   32'(bus.ms_to_ws_valid), 32'd0);

        // reset beats data_ok and a new accept in the same cycle
        issue(32'h900, 5'd13, 32'h900, 3'b001, 32'd0, 1'b1, 1'b0, 5'd0);
        reset = 1'b1;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h1234;
        bus.es_pc = 32'hA00; bus.es_result = 32'hA00; bus.es_to_ms_valid = 1'b1;
        cyc();
        reset = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        bus.es_to_ms_valid = 1'b0;
        #1;
        check("rp_allowin", 32'(bus.ms_allowin), 32'd1);
        check("rp_pc",      bus.ms_pc, 32'd0);
        check("rp_result",  bus.ms_final_result, 32'd0);
        check("rp_valid",   32'(bus.ms_to_ws_valid), 32'd0);
        check("rp_fw",      32'(bus.ms_fw_block), 32'd0);
        issue(32'hB00, 5'd14, 32'hABC, 3'b000, 32'd0, 1'b0, 1'b0, 5'd0);
        #1;
        check("rp_next_v", 32'(bus.ms_to_ws_valid), 32'd1);
        check("rp_next_r", bus.ms_final_result, 32'hABC);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  clock; all state SHALL update on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 es_to_ms_valid  in  1  EX holds a valid instruction for MEM.
REQ-004 ms_allowin  out  1  MEM SHALL accept es_* this cycle when high.
REQ-005 es_pc  in  32  instruction PC.
REQ-006 es_dest  in  5  GPR destination; 0 = no write.
REQ-007 es_result  in  32  ALU result or load address.
REQ-008 es_load_op  in  3  000 none, 001 lw, 010 lb, 011 lbu, 100 lh, 101 lhu, 110 lwl, 111 lwr.
REQ-009 es_rt_value  in  32  old rt value, merged by lwl/lwr.
REQ-010 es_req_sent  in  1  data request accepted in EX; exactly one data_ok owed.
REQ-011 es_excp_valid  in  1  exception raised upstream.
REQ-012 es_excp_execode  in  5  exception code.
REQ-013 data_sram_data_ok  in  1  load/store response strobe, in request order.
REQ-014 data_sram_rdata  in  32  read data, valid with data_ok.
REQ-015 flush  in  1  WB exception/eret/TLB refetch; kills MEM contents.
REQ-016 ws_allowin  in  1  WB accepts this cycle.
REQ-017 ms_to_ws_valid  out  1  ms_* outputs valid for WB.
REQ-018 ms_pc, ms_dest, ms_excp_valid, ms_excp_execode  out  32/5/1/5  registered copies of the es_* fields.
REQ-019 ms_final_result  out  32  load-formatted data or es_result.
REQ-020 ms_fw_block  out  1  valid load still waiting for data; ID SHALL stall on a dest match.

Function
REQ-021 States: IDLE (empty), WAIT (valid, data_ok owed), HOLD (result ready), DISCARD (killed, data_ok still owed).
REQ-022 Accept when es_to_ms_valid && ms_allowin; ms_allowin = IDLE, or HOLD && ws_allowin; never in WAIT/DISCARD.
REQ-023 Accept with es_req_sent=1 -> WAIT; otherwise -> HOLD with ms_final_result=es_result.
REQ-024 WAIT && data_ok -> HOLD next cycle, rdata formatted and latched; response held until WB accepts.
REQ-025 ms_to_ws_valid = HOLD && !flush; leaving HOLD on ws_allowin with no new accept -> IDLE.
REQ-026 lb/lbu: byte at addr[1:0] sign/zero-extended; lh/lhu: half at addr[1]; lw: rdata; addr = latched es_result[1:0].
REQ-027 Misaligned lh/lw are not checked here; EX raises AdEL and clears es_req_sent.
REQ-028 Any es_excp_valid instruction SHALL pass through with dest write suppressed and no data wait.
REQ-029 flush: HOLD -> IDLE; WAIT without same-cycle data_ok -> DISCARD; WAIT with data_ok -> IDLE; no accept that cycle.
REQ-030 DISCARD: next data_ok dropped -> IDLE; ms_to_ws_valid=0 and ms_fw_block=0 throughout.
REQ-031 ms_fw_block = (state==WAIT) && ms_dest!=0.

Reset
REQ-032 reset -> IDLE; all outputs 0; pending data_ok forgotten (memory side is reset together).
REQ-033 reset has priority over flush, data_ok and accept in the same cycle.

Configuration
REQ-034 MS_UNALIGNED_LOAD_EN defined: lwl addr 0..3 = {rdata[7:0],rt[23:0]}, {rdata[15:0],rt[15:0]}, {rdata[23:0],rt[7:0]}, rdata; lwr addr 0..3 = rdata, {rt[31:24],rdata[31:8]}, {rt[31:16],rdata[31:16]}, {rt[31:8],rdata[31:24]}.
REQ-035 MS_UNALIGNED_LOAD_EN undefined: 110/111 SHALL format as lw; es_rt_value unused.

Verification
REQ-036 lb, addr 0x...03, rdata 0x80FF1234, data_ok 2 cycles later -> ms_fw_block=1 for 2 cycles, then result 0xFFFFFF80.
REQ-037 lhu addr[1]=1, rdata 0x9ABC5678, ws_allowin=0 for 3 cycles -> HOLD, result 0x00009ABC stable, ms_allowin=0.
REQ-038 flush in WAIT, data_ok 1 cycle later -> DISCARD then IDLE, no ms_to_ws_valid, data dropped.
REQ-039 es_excp_valid=1, execode 0x04, es_req_sent=0 -> HOLD next cycle, ms_excp_valid=1, no data wait.
REQ-040 EN defined: lwl addr 1, rt 0x11223344, rdata 0xAABBCCDD -> 0xCCDD3344; undefined -> 0xAABBCCDD.
